// File: rtl/oled_spi_receiver.sv
// ST7735-compatible 4-wire SPI receiver: oversamples the link in the clk domain,
// decodes commands, tracks the CASET/RASET window and emits pixel write strobes.
module oled_spi_receiver #(
  parameter int C_x_size = 128,
  parameter int C_y_size = 160,
  parameter int C_x_bits = $clog2(C_x_size),
  parameter int C_y_bits = $clog2(C_y_size)
) (
  input  logic                clk,
  input  logic                resn,
  input  logic                spi_csn,
  input  logic                spi_clk,
  input  logic                spi_mosi,
  input  logic                spi_dc,
  input  logic                spi_resn,
  output logic                byte_valid,
  output logic [7:0]          byte_data,
  output logic                byte_dc,
  output logic                frame_start,
  output logic                pixel_we,
  output logic [C_x_bits-1:0] pixel_x,
  output logic [C_y_bits-1:0] pixel_y,
  output logic [15:0]         pixel_color
);

  localparam logic [C_x_bits-1:0] X_LAST = C_x_bits'(C_x_size - 1);
  localparam logic [C_y_bits-1:0] Y_LAST = C_y_bits'(C_y_size - 1);

  localparam logic [7:0] OP_SWRESET = 8'h01;
  localparam logic [7:0] OP_CASET   = 8'h2A;
  localparam logic [7:0] OP_RASET   = 8'h2B;
  localparam logic [7:0] OP_RAMWR   = 8'h2C;

  typedef enum logic [1:0] {MODE_NONE, MODE_CASET, MODE_RASET, MODE_RAMWR} mode_t;

  logic csnMeta_q, csnSync_q;
  logic sckMeta_q, sckSync_q, sckPrev_q;
  logic mosiMeta_q, mosiSync_q;
  logic dcMeta_q, dcSync_q;
  logic resnMeta_q, resnSync_q;

  logic [2:0] bitCnt_q;
  logic [7:0] shift_q;
  logic       byteValid_q;
  logic [7:0] byteData_q;
  logic       byteDc_q;

  logic       sckRise;
  logic [7:0] shiftNext_d;

  mode_t                 mode_q;
  logic [2:0]            argIdx_q;
  logic                  toggle_q;
  logic [7:0]            colorHi_q;
  logic [7:0]            argStartHi_q, argStartLo_q, argEndHi_q;
  logic [C_x_bits-1:0]   xs_q, xe_q, x_q;
  logic [C_y_bits-1:0]   ys_q, ye_q, y_q;
  logic                  frameStart_q, pixelWe_q;
  logic [C_x_bits-1:0]   pixelX_q;
  logic [C_y_bits-1:0]   pixelY_q;
  logic [15:0]           pixelColor_q;

  logic [15:0]           startWord_d, endWord_d;
  logic [C_x_bits-1:0]   xNext_d;
  logic [C_y_bits-1:0]   yNext_d;
  logic                  unusedWordBits;

  // MOSI and DC share the SCK synchroniser depth, so they line up with the detected edge
  assign sckRise     = sckSync_q & ~sckPrev_q;
  assign shiftNext_d = {shift_q[6:0], mosiSync_q};

  always_ff @(posedge clk) begin
    if (!resn) begin
      csnMeta_q   <= 1'b1;
      csnSync_q   <= 1'b1;
      sckMeta_q   <= 1'b0;
      sckSync_q   <= 1'b0;
      sckPrev_q   <= 1'b0;
      mosiMeta_q  <= 1'b0;
      mosiSync_q  <= 1'b0;
      dcMeta_q    <= 1'b0;
      dcSync_q    <= 1'b0;
      resnMeta_q  <= 1'b1;
      resnSync_q  <= 1'b1;
      bitCnt_q    <= '0;
      shift_q     <= '0;
      byteValid_q <= 1'b0;
      byteData_q  <= '0;
      byteDc_q    <= 1'b0;
    end else begin
      csnMeta_q   <= spi_csn;
      csnSync_q   <= csnMeta_q;
      sckMeta_q   <= spi_clk;
      sckSync_q   <= sckMeta_q;
      sckPrev_q   <= sckSync_q;
      mosiMeta_q  <= spi_mosi;
      mosiSync_q  <= mosiMeta_q;
      dcMeta_q    <= spi_dc;
      dcSync_q    <= dcMeta_q;
      resnMeta_q  <= spi_resn;
      resnSync_q  <= resnMeta_q;
      byteValid_q <= 1'b0;
      // The 8th edge completes its byte even if CSn deasserts in that same cycle
      if (!resnSync_q) begin
        bitCnt_q <= '0;
        shift_q  <= '0;
      end else if (sckRise && (!csnSync_q || bitCnt_q == 3'd7)) begin
        shift_q  <= shiftNext_d;
        bitCnt_q <= bitCnt_q + 3'd1;
        if (bitCnt_q == 3'd7) begin
          byteValid_q <= 1'b1;
          byteData_q  <= shiftNext_d;
          byteDc_q    <= dcSync_q;
        end
      end else if (csnSync_q) begin
        bitCnt_q <= '0;
        shift_q  <= '0;
      end
    end
  end

  assign startWord_d    = {argStartHi_q, argStartLo_q};
  assign endWord_d      = {argEndHi_q, byteData_q};
  assign unusedWordBits = ^{startWord_d, endWord_d};

  always_comb begin
    xNext_d = x_q + 1'b1;
    yNext_d = y_q;
    if (x_q == xe_q || x_q == X_LAST) begin
      xNext_d = xs_q;
      yNext_d = (y_q == ye_q || y_q == Y_LAST) ? ys_q : y_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!resn) begin
      mode_q       <= MODE_NONE;
      argIdx_q     <= '0;
      toggle_q     <= 1'b0;
      colorHi_q    <= '0;
      argStartHi_q <= '0;
      argStartLo_q <= '0;
      argEndHi_q   <= '0;
      xs_q         <= '0;
      xe_q         <= X_LAST;
      ys_q         <= '0;
      ye_q         <= Y_LAST;
      x_q          <= '0;
      y_q          <= '0;
      frameStart_q <= 1'b0;
      pixelWe_q    <= 1'b0;
      pixelX_q     <= '0;
      pixelY_q     <= '0;
      pixelColor_q <= '0;
    end else begin
      frameStart_q <= 1'b0;
      pixelWe_q    <= 1'b0;
      // Soft reset takes priority over any pixel completing in the same cycle
      if (!resnSync_q || (byteValid_q && !byteDc_q && byteData_q == OP_SWRESET)) begin
        mode_q   <= MODE_NONE;
        argIdx_q <= '0;
        toggle_q <= 1'b0;
        xs_q     <= '0;
        xe_q     <= X_LAST;
        ys_q     <= '0;
        ye_q     <= Y_LAST;
        x_q      <= '0;
        y_q      <= '0;
      end else if (byteValid_q && !byteDc_q) begin
        argIdx_q <= '0;
        toggle_q <= 1'b0;
        case (byteData_q)
          OP_CASET: mode_q <= MODE_CASET;
          OP_RASET: mode_q <= MODE_RASET;
          OP_RAMWR: begin
            mode_q       <= MODE_RAMWR;
            x_q          <= xs_q;
            y_q          <= ys_q;
            frameStart_q <= 1'b1;
          end
          default: mode_q <= MODE_NONE;
        endcase
      end else if (byteValid_q) begin
        case (mode_q)
          MODE_CASET, MODE_RASET: begin
            if (argIdx_q != 3'd4) argIdx_q <= argIdx_q + 3'd1;
            case (argIdx_q)
              3'd0: argStartHi_q <= byteData_q;
              3'd1: argStartLo_q <= byteData_q;
              3'd2: argEndHi_q   <= byteData_q;
              3'd3: begin
                if (mode_q == MODE_CASET) begin
                  xs_q <= startWord_d[C_x_bits-1:0];
                  xe_q <= endWord_d[C_x_bits-1:0];
                end else begin
                  ys_q <= startWord_d[C_y_bits-1:0];
                  ye_q <= endWord_d[C_y_bits-1:0];
                end
              end
              default: ;
            endcase
          end
          MODE_RAMWR: begin
            if (!toggle_q) begin
              colorHi_q <= byteData_q;
              toggle_q  <= 1'b1;
            end else begin
              toggle_q     <= 1'b0;
              pixelWe_q    <= 1'b1;
              pixelX_q     <= x_q;
              pixelY_q     <= y_q;
              pixelColor_q <= {colorHi_q, byteData_q};
              x_q          <= xNext_d;
              y_q          <= yNext_d;
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign byte_valid  = byteValid_q;
  assign byte_data   = byteData_q;
  assign byte_dc     = byteDc_q;
  assign frame_start = frameStart_q;
  assign pixel_we    = pixelWe_q;
  assign pixel_x     = pixelX_q;
  assign pixel_y     = pixelY_q;
  assign pixel_color = pixelColor_q;

endmodule

// File: tb/tb_oled_spi_receiver.sv
// Testbench for oled_spi_receiver: bit-banged SPI stimulus, table vectors,
// directed corner sequences and randomized traffic against a window/scan model.
module tb_oled_spi_receiver;

  localparam int XS = 128;
  localparam int YS = 160;
  localparam int XB = $clog2(XS);
  localparam int YB = $clog2(YS);
  localparam int H  = 30;

  logic          clk = 1'b0;
  logic          resn, spi_csn, spi_clk, spi_mosi, spi_dc, spi_resn;
  logic          byte_valid, byte_dc, frame_start, pixel_we;
  logic [7:0]    byte_data;
  logic [XB-1:0] pixel_x;
  logic [YB-1:0] pixel_y;
  logic [15:0]   pixel_color;

  always #5 clk = ~clk;

  oled_spi_receiver #(.C_x_size(XS), .C_y_size(YS)) dut (
    .clk(clk), .resn(resn), .spi_csn(spi_csn), .spi_clk(spi_clk),
    .spi_mosi(spi_mosi), .spi_dc(spi_dc), .spi_resn(spi_resn),
    .byte_valid(byte_valid), .byte_data(byte_data), .byte_dc(byte_dc),
    .frame_start(frame_start), .pixel_we(pixel_we), .pixel_x(pixel_x),
    .pixel_y(pixel_y), .pixel_color(pixel_color)
  );

  typedef struct { logic dc; logic [7:0] data; } byteEv_t;
  typedef struct { int x; int y; int color; } pixEv_t;
  typedef struct { logic dc; logic [7:0] data; bit expPix; int expX; int expY; int expColor; } vec_t;

  int checkCount = 0;
  int failCount  = 0;
  byteEv_t expByteQ[$];
  pixEv_t  expPixQ[$];
  byteEv_t eb;
  pixEv_t  ep;
  vec_t    vecs[$];
  int byteSeen = 0, pixSeen = 0, frameSeen = 0, expFrames = 0;
  logic [31:0] lastX, lastY, lastColor;
  logic [7:0]  lastByte;
  logic        lastDc;
  bit monitorOn = 0;

  int mXs, mXe, mYs, mYe, mX, mY, mOp, mArgCnt, mHi;
  int mArgs[4];
  bit mHaveHi;

  int pixBefore, byteBefore, kind, n, v;
  logic [7:0] rb;
  int wrapX[5] = '{126, 127, 126, 127, 126};
  int wrapY[5] = '{158, 158, 159, 159, 158};

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checkCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  // Reference model: display window and raster position as plain integers
  function automatic void modelReset();
    mXs = 0; mXe = XS - 1; mYs = 0; mYe = YS - 1; mX = 0; mY = 0;
    mOp = 0; mArgCnt = 0; mHaveHi = 0;
  endfunction

  function automatic void modelByte(input bit dc, input int d);
    int s, e;
    if (!dc) begin
      mArgCnt = 0; mHaveHi = 0; mOp = d;
      if (d == 8'h01) modelReset();
      else if (d == 8'h2C) begin mX = mXs; mY = mYs; expFrames++; end
    end else if (mOp == 8'h2A || mOp == 8'h2B) begin
      if (mArgCnt < 4) begin
        mArgs[mArgCnt] = d;
        mArgCnt++;
        if (mArgCnt == 4) begin
          s = mArgs[0] * 256 + mArgs[1];
          e = mArgs[2] * 256 + mArgs[3];
          if (mOp == 8'h2A) begin mXs = s % (1 << XB); mXe = e % (1 << XB); end
          else begin mYs = s % (1 << YB); mYe = e % (1 << YB); end
        end
      end
    end else if (mOp == 8'h2C) begin
      if (!mHaveHi) begin mHi = d; mHaveHi = 1; end
      else begin
        expPixQ.push_back('{mX, mY, mHi * 256 + d});
        mHaveHi = 0;
        if (mX == mXe || mX == XS - 1) begin
          mX = mXs;
          if (mY == mYe || mY == YS - 1) mY = mYs; else mY = mY + 1;
        end else mX = mX + 1;
      end
    end
  endfunction

  always @(negedge clk) begin
    if (monitorOn) begin
      if (byte_valid) begin
        byteSeen++;
        lastByte = byte_data;
        lastDc = byte_dc;
        checkOutput("byte_expected", 32'(expByteQ.size() > 0), 1);
        if (expByteQ.size() > 0) begin
          eb = expByteQ.pop_front();
          checkOutput("byte_data", byte_data, eb.data);
          checkOutput("byte_dc", byte_dc, eb.dc);
        end
      end
      if (pixel_we) begin
        pixSeen++;
        lastX = pixel_x; lastY = pixel_y; lastColor = pixel_color;
        checkOutput("pixel_expected", 32'(expPixQ.size() > 0), 1);
        if (expPixQ.size() > 0) begin
          ep = expPixQ.pop_front();
          checkOutput("pixel_x", pixel_x, ep.x);
          checkOutput("pixel_y", pixel_y, ep.y);
          checkOutput("pixel_color", pixel_color, ep.color);
        end
      end
      if (frame_start) frameSeen++;
    end
  end

  task automatic idle(input int cycles);
    repeat (cycles) @(posedge clk);
    #2;
  endtask

  task automatic applyStimulus(input bit dc, input logic [7:0] data, input bit csnWithLast = 1'b0);
    modelByte(dc, int'(data));
    expByteQ.push_back('{dc, data});
    spi_dc = dc;
    spi_csn = 1'b0;
    for (int i = 7; i >= 0; i--) begin
      spi_mosi = data[i];
      #H;
      spi_clk = 1'b1;
      if (i == 0 && csnWithLast) spi_csn = 1'b1;
      #H;
      spi_clk = 1'b0;
    end
  endtask

  task automatic sendPartial(input logic [7:0] data, input int nbits);
    spi_csn = 1'b0;
    for (int i = 7; i > 7 - nbits; i--) begin
      spi_mosi = data[i];
      #H;
      spi_clk = 1'b1;
      #H;
      spi_clk = 1'b0;
    end
    #H;
    spi_csn = 1'b1;
    #(4 * H);
  endtask

  task automatic csnHigh();
    #H;
    spi_csn = 1'b1;
    #(2 * H);
  endtask

  task automatic pulseSpiResn();
    modelReset();
    csnHigh();
    spi_resn = 1'b0;
    #40;
    spi_resn = 1'b1;
    #60;
  endtask

  task automatic sendPixel(input int color);
    applyStimulus(1'b1, 8'(color >> 8));
    applyStimulus(1'b1, 8'(color));
    idle(3);
  endtask

  initial begin
    resn = 1'b0; spi_csn = 1'b1; spi_clk = 1'b0; spi_mosi = 1'b0;
    spi_dc = 1'b0; spi_resn = 1'b1;
    modelReset();
    repeat (4) @(posedge clk);
    @(negedge clk);
    checkOutput("reset_byte_valid", byte_valid, 0);
    checkOutput("reset_byte_data", byte_data, 0);
    checkOutput("reset_byte_dc", byte_dc, 0);
    checkOutput("reset_frame_start", frame_start, 0);
    checkOutput("reset_pixel_we", pixel_we, 0);
    checkOutput("reset_pixel_x", pixel_x, 0);
    checkOutput("reset_pixel_y", pixel_y, 0);
    checkOutput("reset_pixel_color", pixel_color, 0);
    @(posedge clk);
    #2;
    resn = 1'b1;
    monitorOn = 1;
    idle(4);

    // Window 5..10 x 3..4 then twelve pixels walking the window
    vecs.push_back('{1'b0, 8'h2A, 0, 0, 0, 0});
    vecs.push_back('{1'b1, 8'h00, 0, 0, 0, 0});
    vecs.push_back('{1'b1, 8'h05, 0, 0, 0, 0});
    vecs.push_back('{1'b1, 8'h00, 0, 0, 0, 0});
    vecs.push_back('{1'b1, 8'h0A, 0, 0, 0, 0});
    vecs.push_back('{1'b0, 8'h2B, 0, 0, 0, 0});
    vecs.push_back('{1'b1, 8'h00, 0, 0, 0, 0});
    vecs.push_back('{1'b1, 8'h03, 0, 0, 0, 0});
    vecs.push_back('{1'b1, 8'h00, 0, 0, 0, 0});
    vecs.push_back('{1'b1, 8'h04, 0, 0, 0, 0});
    vecs.push_back('{1'b0, 8'h2C, 0, 0, 0, 0});
    for (int k = 0; k < 12; k++) begin
      vecs.push_back('{1'b1, 8'h00, 0, 0, 0, 0});
      vecs.push_back('{1'b1, 8'(k), 1, 5 + k % 6, 3 + k / 6, k});
    end
    foreach (vecs[i]) begin
      pixBefore = pixSeen;
      byteBefore = byteSeen;
      applyStimulus(vecs[i].dc, vecs[i].data);
      idle(3);
      checkOutput("vec_byte_count", byteSeen - byteBefore, 1);
      checkOutput("vec_byte_data", lastByte, vecs[i].data);
      checkOutput("vec_byte_dc", lastDc, vecs[i].dc);
      checkOutput("vec_pixel_count", pixSeen - pixBefore, vecs[i].expPix);
      if (vecs[i].expPix) begin
        checkOutput("vec_pixel_x", lastX, vecs[i].expX);
        checkOutput("vec_pixel_y", lastY, vecs[i].expY);
        checkOutput("vec_pixel_color", lastColor, vecs[i].expColor);
      end
    end
    checkOutput("frame_start_once", frameSeen, 1);

    // Incomplete CASET must leave the default window in place
    applyStimulus(1'b0, 8'h01);
    applyStimulus(1'b0, 8'h2A);
    applyStimulus(1'b1, 8'h00);
    applyStimulus(1'b1, 8'h05);
    applyStimulus(1'b0, 8'h00);
    applyStimulus(1'b0, 8'h2C);
    sendPixel(16'hAAAA);
    checkOutput("partial_caset_x0", lastX, 0);
    sendPixel(16'h5555);
    checkOutput("partial_caset_x1", lastX, 1);
    checkOutput("partial_caset_y", lastY, 0);

    // spi_resn restores full window and origin
    applyStimulus(1'b0, 8'h2A);
    applyStimulus(1'b1, 8'h00);
    applyStimulus(1'b1, 8'h05);
    applyStimulus(1'b1, 8'h00);
    applyStimulus(1'b1, 8'h0A);
    applyStimulus(1'b0, 8'h2C);
    sendPixel(16'h1234);
    checkOutput("window_x_before_reset", lastX, 5);
    pulseSpiResn();
    applyStimulus(1'b0, 8'h2C);
    sendPixel(16'h4321);
    checkOutput("hwreset_x", lastX, 0);
    checkOutput("hwreset_y", lastY, 0);
    sendPixel(16'h0F0F);
    checkOutput("hwreset_next_x", lastX, 1);

    // Aborted partial byte then a complete one
    applyStimulus(1'b0, 8'h00);
    csnHigh();
    byteBefore = byteSeen;
    sendPartial(8'hFF, 5);
    applyStimulus(1'b1, 8'hA5);
    idle(3);
    checkOutput("abort_byte_count", byteSeen - byteBefore, 1);
    checkOutput("abort_byte_data", lastByte, 8'hA5);
    checkOutput("abort_byte_dc", lastDc, 1);

    // CSn deasserting together with the 8th SCK rise
    byteBefore = byteSeen;
    applyStimulus(1'b1, 8'h3C, 1'b1);
    idle(4);
    checkOutput("csn_last_edge_count", byteSeen - byteBefore, 1);
    checkOutput("csn_last_edge_data", lastByte, 8'h3C);

    // Reversed column window at the panel edge plus bottom-row wrap
    applyStimulus(1'b0, 8'h2A);
    applyStimulus(1'b1, 8'h00);
    applyStimulus(1'b1, 8'h7E);
    applyStimulus(1'b1, 8'h00);
    applyStimulus(1'b1, 8'h85);
    applyStimulus(1'b0, 8'h2B);
    applyStimulus(1'b1, 8'h00);
    applyStimulus(1'b1, 8'h9E);
    applyStimulus(1'b1, 8'h00);
    applyStimulus(1'b1, 8'h9F);
    applyStimulus(1'b0, 8'h2C);
    for (int k = 0; k < 5; k++) begin
      sendPixel(16'hC000 + k);
      checkOutput("wrap_x", lastX, wrapX[k]);
      checkOutput("wrap_y", lastY, wrapY[k]);
    end

    for (int t = 0; t < 120; t++) begin
      kind = $urandom_range(0, 9);
      case (kind)
        0, 1: begin
          applyStimulus(1'b0, (kind == 0) ? 8'h2A : 8'h2B);
          n = $urandom_range(0, 5);
          for (int j = 0; j < n; j++) begin
            if (kind == 1 && (j == 1 || j == 3)) v = $urandom_range(0, YS - 1);
            else v = $urandom_range(0, 255);
            applyStimulus(1'b1, 8'(v));
          end
        end
        2, 3, 4: begin
          applyStimulus(1'b0, 8'h2C);
          n = $urandom_range(0, 12);
          for (int j = 0; j < n; j++) applyStimulus(1'b1, 8'($urandom_range(0, 255)));
        end
        5: begin
          applyStimulus(1'b0, ($urandom_range(0, 1) == 0) ? 8'h00 : 8'h55);
          n = $urandom_range(0, 3);
          for (int j = 0; j < n; j++) applyStimulus(1'b1, 8'($urandom_range(0, 255)));
        end
        6: applyStimulus(1'b0, 8'h01);
        7: pulseSpiResn();
        8: begin
          csnHigh();
          rb = 8'($urandom_range(0, 255));
          sendPartial(rb, $urandom_range(1, 7));
        end
        default: begin
          n = $urandom_range(1, 6);
          for (int j = 0; j < n; j++) applyStimulus(1'b1, 8'($urandom_range(0, 255)));
        end
      endcase
    end

    csnHigh();
    idle(10);
    checkOutput("bytes_all_seen", expByteQ.size(), 0);
    checkOutput("pixels_all_seen", expPixQ.size(), 0);
    checkOutput("frame_start_total", frameSeen, expFrames);
    $display("End of test - %0d assertions evaluated, %0d failures", checkCount, failCount);
    $finish;
  end

endmodule

// File: doc/oled_spi_receiver.md
# oled_spi_receiver

Receiving end of the ST7735 4-wire SPI display link. It oversamples CSn/SCK/MOSI/DC in the `clk` domain and decodes bytes into commands and parameters. It tracks the CASET/RASET address window and turns RAMWR pixel data into framebuffer write strobes `(x, y, color)`. It sits where a physical ST7735 would: a second board, a framebuffer-backed HDMI mirror, or a loopback bench for the display driver.

## Interface
- `C_x_size`, 128: columns; default column window end = `C_x_size-1`.
- `C_y_size`, 160: rows; default row window end = `C_y_size-1`.
- `C_x_bits`, `$clog2(C_x_size)` = 7: pixel_x width.
- `C_y_bits`, `$clog2(C_y_size)` = 8: pixel_y width.

Ports:
- `clk`  in  1  system clock; must be ≥4× SCK frequency (SCK high ≥2 clk and low ≥2 clk).
- `resn`  in  1  reset; one clock, reset synchronous, active-low.
- `spi_csn`  in  1  chip select, active low, asynchronous to clk.
- `spi_clk`  in  1  SCK, mode 0; data sampled on the rising edge.
- `spi_mosi`  in  1  serial data, MSB first.
- `spi_dc`  in  1  0 = command byte, 1 = parameter/pixel byte.
- `spi_resn`  in  1  display hardware reset, active low.
- `byte_valid`  out  1  one-cycle pulse per received byte.
- `byte_data`  out  8  last received byte.
- `byte_dc`  out  1  DC captured with that byte.
- `frame_start`  out  1  one-cycle pulse on RAMWR command.
- `pixel_we`  out  1  one-cycle pixel write strobe.
- `pixel_x`  out  C_x_bits  write column.
- `pixel_y`  out  C_y_bits  write row.
- `pixel_color`  out  16  RGB565 pixel.

## Operation
- **Input synchronisers.** `spi_csn`, `spi_clk`, `spi_mosi`, `spi_dc` and `spi_resn` each pass through 2-flop synchronisers. A third flop on `spi_clk` provides rising-edge detection. All paths have equal delay, so MOSI and DC align with the detected edge.
- **Shift register.**
  - While synced CSn is high, the bit counter and shift register clear.
  - On each detected SCK rise with CSn low, shift in MOSI MSB-first.
  - On the 8th bit: pulse `byte_valid`, latch `byte_data`, and latch `byte_dc` from DC at that edge.
  - A CSn rise mid-byte discards the partial byte.
- **Command decoder** (byte_dc=0): store the opcode and clear the argument index and pixel-phase toggle.
  - 0x2A CASET: column window.
  - 0x2B RASET: row window.
  - 0x2C RAMWR: set x←xs, y←ys and pulse `frame_start`.
  - 0x01 SWRESET: apply the soft-reset state.
  - All others, including 0x00 NOP: args ignored.
- **CASET/RASET arguments** (byte_dc=1), in order: start[15:8], start[7:0], end[15:8], end[7:0].
  - Bytes go into shadow registers.
  - The window commits only on the 4th arg, using the low C_x_bits/C_y_bits of each 16-bit value.
  - Args beyond the 4th are ignored. A new command before the 4th arg discards the shadow.
- **RAMWR data:**
  - Even bytes go to color[15:8], odd bytes to color[7:0].
  - On each odd byte, pulse `pixel_we` with the current x, y and the assembled color, then advance.
  - **Advance rule:** if x==xe or x==C_x_size-1, then x←xs and y advances; otherwise x←x+1.
  - **y advance:** if y==ye or y==C_y_size-1, then y←ys (wrap to window top); otherwise y←y+1.
  - The same rule applies when xs>xe.
  - Data bytes outside RAMWR, CASET or RASET are ignored.
- **Soft-reset state** (resn low, synced spi_resn low, or SWRESET):
  - xs=0, xe=C_x_size-1, ys=0, ye=C_y_size-1, x=y=0.
  - Opcode cleared to NOP; arg index and toggle cleared.
  - spi_resn low also clears the bit counter.

## Timing
- **Reset values** (resn low at a clk edge): all outputs 0. Synchroniser flops are set to CSn=1, SCK=0, resn=1.
- **byte_valid latency:** `byte_valid` is high in the cycle after the 3rd clk edge following the raw SCK rise of bit 7.
- **pixel_we latency:** `pixel_we` is asserted one cycle after the `byte_valid` of the low byte. That is 4 clk edges after the raw SCK rise.
- **Output hold:** pixel_x, pixel_y and pixel_color are valid and stable only while `pixel_we`=1. byte_data and byte_dc hold until the next byte.
- **frame_start latency:** `frame_start` occurs one cycle after the RAMWR `byte_valid`. Window updates are usable from the cycle after the 4th-arg `byte_valid`.
- **Sustained throughput:** one byte per 8 SCK periods. There is no back-pressure, so the consumer must accept `pixel_we` every cycle it fires.
- **Simultaneous events:**
  - SWRESET or spi_resn together with a pending pixel: the reset wins and no `pixel_we` is issued.
  - CSn rising in the same cycle as the 8th edge: the byte still completes.

## Test plan
- Send cmd 0x2A then args 00 05 00 0A, then 0x2B with 00 03 00 04, then 0x2C and 12 pixels (0x0000..0x000B) → writes cover x=5..10 at y=3 then y=4, all 12 writes. `frame_start` pulses once.
- RAMWR with no window set, then 128×160+1 pixels → last x=127,y=159 then wrap to (0,0). `pixel_we` count = 20481.
- CASET with only 2 args then NOP, then RAMWR with 2 pixels → window unchanged (x=0,1). byte_valid/byte_dc match every byte.
- CSn high after 5 bits of a byte, then full byte 0xA5 with DC=1 → single `byte_valid` with 0xA5, byte_dc=1.
- Window x=5..10 active, then spi_resn low 4 cycles or SWRESET → next RAMWR starts at (0,0) with full window.
- Loopback with the display driver at clk/8 SCK → every init byte reproduced in order with correct DC. Pixel stream (x,y) matches the driver's x/y scan for two frames.
